// File: rtl/uart_pkg.sv
// Shared UART register-access definitions: address type and command-byte layout.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    typedef logic [2:0] reg_rwaddr;

    localparam int CMD_WRITE_BIT = 0;
    localparam int CMD_ADDR_LSB  = 1;
    localparam int CMD_ADDR_MSB  = 3;

    // Command byte on the wire: {4'b0000, addr[2:0], write}
    function automatic logic [7:0] make_cmd_byte(input reg_rwaddr addr, input logic write);
        logic [7:0] b;
        b = 8'h00;
        b[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
        b[CMD_WRITE_BIT]             = write;
        return b;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Read-response timeout counter: counts enabled cycles, flags TIMEOUT_CYCLES-1.
// Latency: o_expired is a compare on the registered count (same cycle as count).
// Backpressure: none; holds at the expiry value until cleared.
// Ports: i_clk, i_rst (sync, active-high), i_clr (restart at 0), i_en (count), o_expired.
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && !o_expired) begin
            // Saturate at expiry so a late disable can never wrap the count
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/cmd_initiator.sv
// Host-to-UART register initiator: serialises one write/read command, returns one response.
// Latency: tx byte the cycle after accept; response one cycle after last tx / rx / timeout.
// Backpressure: o_req_ready only in IDLE; tx byte held stable while i_tx_ready is low.
// Ports: i_clk, i_rst; host req (i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_wdata);
//        UART tx (o_tx_data, o_tx_data_valid, i_tx_ready); UART rx (i_rx_data, i_rx_data_valid);
//        response (o_rsp_valid, o_rsp_data, o_rsp_timeout); o_rx_unexpected.
module cmd_initiator
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_write,
    input  reg_rwaddr  i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic [7:0] o_tx_data,
    output logic       o_tx_data_valid,
    input  logic       i_tx_ready,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_valid,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_timeout,
    output logic       o_rx_unexpected
);
    typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_DATA, WAIT_RSP, DONE} state_t;

    state_t     state_q, state_d;
    // The address only travels inside the registered command byte, so just the
    // write flag and write data need a copy for the later states.
    logic       lat_write_q;
    logic [7:0] lat_wdata_q;

    logic [7:0] tx_data_d;
    logic       tx_vld_d;
    logic       rsp_vld_d;
    logic [7:0] rsp_data_d;
    logic       rsp_to_d;
    logic       rx_unexp_d;

    logic       req_acc;
    logic       tx_hs;
    logic       cmd_hs;
    logic       tmr_en;
    logic       tmr_expired;

    assign o_req_ready = (state_q == IDLE);
    assign req_acc     = i_req_valid && o_req_ready;
    assign tx_hs       = o_tx_data_valid && i_tx_ready;
    assign cmd_hs      = (state_q == SEND_CMD) && tx_hs;
    assign tmr_en      = (state_q == WAIT_RSP);

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (cmd_hs),
        .i_en      (tmr_en),
        .o_expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = o_tx_data;
        tx_vld_d   = o_tx_data_valid;
        rsp_vld_d  = 1'b0;
        rsp_data_d = 8'h00;
        rsp_to_d   = 1'b0;
        // Stray rx bytes are only reported; they never touch the transaction
        rx_unexp_d = i_rx_data_valid && (state_q != WAIT_RSP);

        case (state_q)
            IDLE: begin
                if (req_acc) begin
                    state_d   = SEND_CMD;
                    tx_data_d = make_cmd_byte(i_req_addr, i_req_write);
                    tx_vld_d  = 1'b1;
                end
            end
            SEND_CMD: begin
                if (tx_hs) begin
                    if (lat_write_q) begin
                        state_d   = SEND_DATA;
                        tx_data_d = lat_wdata_q;
                    end else begin
                        state_d   = WAIT_RSP;
                        tx_data_d = 8'h00;
                        tx_vld_d  = 1'b0;
                    end
                end
            end
            SEND_DATA: begin
                if (tx_hs) begin
                    state_d   = DONE;
                    tx_data_d = 8'h00;
                    tx_vld_d  = 1'b0;
                    rsp_vld_d = 1'b1;
                end
            end
            WAIT_RSP: begin
                // rx checked first so a byte on the expiry cycle still wins
                if (i_rx_data_valid) begin
                    state_d    = DONE;
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = i_rx_data;
                end else if (tmr_expired) begin
                    state_d   = DONE;
                    rsp_vld_d = 1'b1;
                    rsp_to_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            lat_write_q     <= 1'b0;
            lat_wdata_q     <= 8'h00;
            o_tx_data       <= 8'h00;
            o_tx_data_valid <= 1'b0;
            o_rsp_valid     <= 1'b0;
            o_rsp_data      <= 8'h00;
            o_rsp_timeout   <= 1'b0;
            o_rx_unexpected <= 1'b0;
        end else begin
            state_q         <= state_d;
            o_tx_data       <= tx_data_d;
            o_tx_data_valid <= tx_vld_d;
            o_rsp_valid     <= rsp_vld_d;
            o_rsp_data      <= rsp_data_d;
            o_rsp_timeout   <= rsp_to_d;
            o_rx_unexpected <= rx_unexp_d;
            if (req_acc) begin
                lat_write_q <= i_req_write;
                lat_wdata_q <= i_req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// Scoreboard bench for cmd_initiator: randomized and directed register transactions.
// Expected tx bytes / responses are queued at issue time; a negedge monitor pops and compares.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cmd_initiator;
    localparam int T = 16;

    typedef struct {
        logic [7:0] b;
        bit         rd_cmd;
    } tx_exp_t;

    typedef struct {
        logic [7:0] d;
        bit         to;
        int         lat;
    } rsp_exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic       i_req_write = 1'b0;
    logic [2:0] i_req_addr = 3'd0;
    logic [7:0] i_req_wdata = 8'h00;
    logic [7:0] o_tx_data;
    logic       o_tx_data_valid;
    logic       i_tx_ready = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_data_valid = 1'b0;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic       o_rsp_timeout;
    logic       o_rx_unexpected;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_edge  = 0;
    int last_acc = 0;
    int unexp_seen = 0;
    int unexp_exp  = 0;

    bit         rand_rdy = 1'b0;
    bit         stall    = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    tx_exp_t  exp_tx[$];
    rsp_exp_t exp_rsp[$];

    cmd_initiator #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_write     (i_req_write),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .o_tx_data       (o_tx_data),
        .o_tx_data_valid (o_tx_data_valid),
        .i_tx_ready      (i_tx_ready),
        .i_rx_data       (i_rx_data),
        .i_rx_data_valid (i_rx_data_valid),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_timeout   (o_rsp_timeout),
        .o_rx_unexpected (o_rx_unexpected)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Transmitter model: random acceptance or a directed stall
    always @(posedge i_clk) begin
        #1;
        i_tx_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : !stall;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge i_clk) begin
        tx_exp_t  te;
        rsp_exp_t re;
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check(o_tx_data_valid == 1'b1, "tx_valid_held", int'(o_tx_data_valid), 1);
                check(o_tx_data == prev_dat, "tx_data_held", int'(o_tx_data), int'(prev_dat));
            end
            prev_stall = o_tx_data_valid && !i_tx_ready;
            prev_dat   = o_tx_data;
            if (o_tx_data_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check(1'b0, "tx_extra_byte", int'(o_tx_data), 0);
                end else begin
                    te = exp_tx.pop_front();
                    check(o_tx_data == te.b, "tx_byte", int'(o_tx_data), int'(te.b));
                    if (te.rd_cmd) hs_edge = cyc + 1;
                end
            end
            if (o_rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check(1'b0, "rsp_extra", int'(o_rsp_data), 0);
                end else begin
                    re = exp_rsp.pop_front();
                    check(o_rsp_data == re.d, "rsp_data", int'(o_rsp_data), int'(re.d));
                    check(o_rsp_timeout == re.to, "rsp_timeout", int'(o_rsp_timeout), int'(re.to));
                    if (re.lat >= 0)
                        check((cyc - hs_edge) == re.lat, "rsp_latency", cyc - hs_edge, re.lat);
                end
            end
            if (o_rx_unexpected) unexp_seen++;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request as soon as the DUT is idle; queue its command byte
    task automatic issue(input logic wr, input logic [2:0] addr, input logic [7:0] wdata);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_req_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) check(1'b0, "req_ready_timeout", 0, 1);
        exp_tx.push_back('{b: 8'(int'(addr) * 2 + int'(wr)), rd_cmd: !wr});
        if (wr) exp_tx.push_back('{b: wdata, rd_cmd: 1'b0});
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        step();
        i_req_valid = 1'b0;
        last_acc    = cyc;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] wdata);
        issue(1'b1, addr, wdata);
        exp_rsp.push_back('{d: 8'h00, to: 1'b0, lat: -1});
    endtask

    // d = 1..T: rx byte sampled d edges after the command handshake; d = 0: no rx
    task automatic do_read(input logic [2:0] addr, input int d, input logic [7:0] rxd);
        bit got;
        issue(1'b0, addr, 8'h00);
        if (d >= 1 && d <= T) exp_rsp.push_back('{d: rxd, to: 1'b0, lat: d});
        else                  exp_rsp.push_back('{d: 8'h00, to: 1'b1, lat: T});
        if (d >= 1) begin
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge i_clk);
                if (o_tx_data_valid && i_tx_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) check(1'b0, "cmd_handshake_timeout", 0, 1);
            step();
            repeat (d - 1) step();
            i_rx_data_valid = 1'b1;
            i_rx_data       = rxd;
            step();
            i_rx_data_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (o_req_ready && exp_rsp.size() == 0) break;
            step();
        end
    endtask

    initial begin
        int a0;
        bit got;

        // Reset state
        repeat (3) step();
        check(o_req_ready == 1'b1, "rst_req_ready", int'(o_req_ready), 1);
        check(o_tx_data_valid == 1'b0, "rst_tx_valid", int'(o_tx_data_valid), 0);
        check(o_tx_data == 8'h00, "rst_tx_data", int'(o_tx_data), 0);
        check(o_rsp_valid == 1'b0, "rst_rsp_valid", int'(o_rsp_valid), 0);
        check(o_rsp_data == 8'h00, "rst_rsp_data", int'(o_rsp_data), 0);
        check(o_rsp_timeout == 1'b0, "rst_rsp_timeout", int'(o_rsp_timeout), 0);
        check(o_rx_unexpected == 1'b0, "rst_rx_unexp", int'(o_rx_unexpected), 0);
        i_rst = 1'b0;
        step();

        // Directed: write 5/A7, read 2 with rx at 10, timeout, rx on expiry cycle
        do_write(3'd5, 8'hA7);
        do_read(3'd2, 10, 8'h3C);
        do_read(3'd6, 0, 8'h00);
        do_read(3'd1, T, 8'h5A);

        // Back-to-back writes with ready tied high: 4-cycle accept spacing
        wait_idle();
        do_write(3'd3, 8'h11);
        a0 = last_acc;
        do_write(3'd4, 8'h22);
        check((last_acc - a0) == 4, "req_spacing", last_acc - a0, 4);

        // Transmitter stalled for 7 cycles during a write
        wait_idle();
        stall = 1'b1;
        step();
        do_write(3'd7, 8'hC3);
        repeat (7) step();
        stall = 1'b0;

        // Stray rx byte while idle, then a normal read
        wait_idle();
        i_rx_data_valid = 1'b1;
        i_rx_data       = 8'hFF;
        unexp_exp++;
        step();
        i_rx_data_valid = 1'b0;
        step();
        check(unexp_seen == unexp_exp, "rx_unexpected_idle", unexp_seen, unexp_exp);
        do_read(3'd0, 3, 8'h96);

        // Randomized traffic with random transmitter backpressure
        wait_idle();
        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            end else begin
                if ($urandom_range(0, 4) == 0)
                    do_read(3'($urandom_range(0, 7)), 0, 8'h00);
                else
                    do_read(3'($urandom_range(0, 7)), int'($urandom_range(1, T)),
                            8'($urandom_range(0, 255)));
            end
        end
        wait_idle();
        rand_rdy = 1'b0;
        step();

        // Reset while waiting for a read response
        do_read(3'd2, 0, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (o_tx_data_valid && i_tx_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check(1'b0, "cmd_handshake_timeout", 0, 1);
        step();
        repeat (5) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_rsp.delete();
        check(o_req_ready == 1'b1, "post_rst_req_ready", int'(o_req_ready), 1);
        check(o_rsp_valid == 1'b0, "post_rst_rsp_valid", int'(o_rsp_valid), 0);
        check(o_tx_data_valid == 1'b0, "post_rst_tx_valid", int'(o_tx_data_valid), 0);
        i_rx_data_valid = 1'b1;
        i_rx_data       = 8'h77;
        unexp_exp++;
        step();
        i_rx_data_valid = 1'b0;
        repeat (T + 4) step();

        // Drain and final accounting
        for (int i = 0; i < 500; i++) begin
            if (exp_tx.size() == 0 && exp_rsp.size() == 0) break;
            step();
        end
        check(exp_tx.size() == 0, "tx_bytes_missing", exp_tx.size(), 0);
        check(exp_rsp.size() == 0, "rsp_missing", exp_rsp.size(), 0);
        check(unexp_seen == unexp_exp, "rx_unexpected_count", unexp_seen, unexp_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
